spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameters ADDR_WIDTH, default 32, register-port address width; DATA_WIDTH, default 32, register-port data width.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port i_wen  in  4  byte strobes from the AXI-Lite slave bridge.
REQ-005 SHALL have port i_addr_w  in  ADDR_WIDTH  register write address.
REQ-006 SHALL have port i_data_w  in  DATA_WIDTH  register write data.
REQ-007 SHALL have port i_valid_w  in  1  one-cycle write-commit pulse.
REQ-008 SHALL have port i_addr_r  in  ADDR_WIDTH  register read address.
REQ-009 SHALL have port i_valid_r  in  1  one-cycle read-complete pulse, used for read side effects.
REQ-010 SHALL have port o_data_r  out  DATA_WIDTH  combinational read data decoded from i_addr_r.
REQ-011 SHALL have ports o_spi_sclk, o_spi_mosi, o_spi_cs_n  out  1 each, and i_spi_miso  in  1.
REQ-012 SHALL have port o_irq  out  1  level interrupt.

Function
REQ-013 SHALL decode registers on i_addr_w/i_addr_r[4:2]: 0 CTRL, 1 CLKDIV, 2 TXDATA, 3 RXDATA, 4 STATUS, others read 0 and ignore writes.
REQ-014 SHALL latch the most recent nonzero i_wen; on i_valid_w, SHALL write only byte lanes enabled in that latched value, then clear it.
REQ-015 CTRL SHALL hold: bit0 EN, bit1 CPOL, bit2 CPHA, bit3 LSB_FIRST, bit4 IRQ_EN, bit5 CS_HOLD; reset 0.
REQ-016 CLKDIV[15:0] SHALL set the SCLK half-period to CLKDIV+1 clk cycles; reset 0x0004.
REQ-017 A TXDATA write with EN=1 and BUSY=0 SHALL start a transfer of i_data_w[7:0]; a TXDATA write while BUSY=1 or EN=0 SHALL be dropped and SHALL set TX_OVF.
REQ-018 At transfer start, SHALL snapshot CLKDIV, CPOL, CPHA, LSB_FIRST; later writes affect only the next transfer.
REQ-019 FSM SHALL be IDLE -> SETUP (1 half-period, cs_n low, sclk=CPOL) -> SHIFT (16 half-periods, sclk toggles each) -> HOLD (1 half-period, sclk=CPOL) -> IDLE.
REQ-020 BUSY and cs_n low SHALL take effect the cycle after the TXDATA commit; BUSY SHALL clear 18*(CLKDIV+1) cycles after it.
REQ-021 With CPHA=0, SHALL drive the first MOSI bit in SETUP, sample MISO on leading edges and shift on trailing edges; with CPHA=1, SHALL shift on leading and sample on trailing edges.
REQ-022 Bit order SHALL be MSB first unless LSB_FIRST=1; the same order SHALL apply to MOSI and MISO.
REQ-023 On entering IDLE, SHALL load RXDATA[7:0] and set RX_VALID; if RX_VALID was already 1, SHALL also set RX_OVR.
REQ-024 cs_n SHALL return high in IDLE unless CS_HOLD=1; clearing CS_HOLD while IDLE SHALL raise cs_n the next cycle.
REQ-025 i_valid_r with read address RXDATA SHALL clear RX_VALID; if this coincides with a new byte load, the load SHALL win and RX_VALID SHALL stay 1.
REQ-026 STATUS SHALL be: bit0 BUSY, bit1 RX_VALID, bit2 TX_OVF, bit3 RX_OVR; bits 2-3 SHALL be write-1-to-clear; a hardware set in the same cycle SHALL win.
REQ-027 o_irq SHALL equal IRQ_EN & RX_VALID.
REQ-028 Clearing EN during a transfer SHALL abort it the next cycle: IDLE, cs_n high, sclk=CPOL, RXDATA and RX_VALID unchanged.
REQ-029 sclk, mosi and cs_n SHALL be registered outputs.

Reset
REQ-030 On resetn low, SHALL immediately force: FSM IDLE; CTRL 0; CLKDIV 0x0004; RXDATA 0; STATUS 0; o_spi_cs_n 1; o_spi_sclk 0; o_spi_mosi 0; o_irq 0; latched strobes 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no RX update.

Verification
REQ-032 CTRL=0x01, CLKDIV=0, TXDATA=0xA5 with MISO looped to MOSI -> 8 sclk pulses, MOSI 1,0,1,0,0,1,0,1; BUSY clears 18 cycles after commit; RXDATA=0xA5.
REQ-033 CTRL=0x0F (CPOL=1, CPHA=1, LSB first), CLKDIV=3, TXDATA=0x01, MISO tied 1 -> sclk idles 1; half-period 4 cycles; first MOSI bit 1; RXDATA=0xFF.
REQ-034 Second TXDATA write while BUSY -> dropped; STATUS=0x05; writing STATUS=0x04 -> TX_OVF cleared.
REQ-035 Two transfers with no RXDATA read, IRQ_EN=1 -> RX_OVR=1, o_irq=1; RXDATA read -> RX_VALID=0, o_irq=0.
REQ-036 EN cleared at the 5th sclk edge -> cs_n high next cycle, BUSY=0, RXDATA unchanged; resetn low mid-transfer -> all REQ-030 values.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// ============================================================================
// Module  : spi_master_ctrl_if
// Brief   : Register-port bundle between the AXI-Lite slave bridge and the
//           SPI master controller.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spi_master_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            i_wen;
  logic [ADDR_WIDTH-1:0] i_addr_w;
  logic [DATA_WIDTH-1:0] i_data_w;
  logic                  i_valid_w;
  logic [ADDR_WIDTH-1:0] i_addr_r;
  logic                  i_valid_r;
  logic [DATA_WIDTH-1:0] o_data_r;

  modport master (
    output i_wen, i_addr_w, i_data_w, i_valid_w, i_addr_r, i_valid_r,
    input  o_data_r
  );

  modport slave (
    input  i_wen, i_addr_w, i_data_w, i_valid_w, i_addr_r, i_valid_r,
    output o_data_r
  );
endinterface

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// ============================================================================
// Module  : spi_master_ctrl
// Brief   : Single-byte SPI master with CPOL/CPHA/bit-order control and a
//           small register file (CTRL, CLKDIV, TXDATA, RXDATA, STATUS).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_master_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                resetn,
  spi_master_ctrl_if.slave    bus,
  output logic                o_spi_sclk,
  output logic                o_spi_mosi,
  output logic                o_spi_cs_n,
  input  logic                i_spi_miso,
  output logic                o_irq
);

  localparam logic [2:0] c_reg_ctrl   = 3'd0;
  localparam logic [2:0] c_reg_clkdiv = 3'd1;
  localparam logic [2:0] c_reg_txdata = 3'd2;
  localparam logic [2:0] c_reg_rxdata = 3'd3;
  localparam logic [2:0] c_reg_status = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_cnt, w_cnt_nxt;
  logic [3:0]      r_hp, w_hp_nxt;
  logic            w_edge, w_enter_hold, w_done;

  logic [3:0]      r_wen;
  logic [5:0]      r_ctrl, w_ctrl_nxt;
  logic [15:0]     r_clkdiv;
  logic [7:0]      r_rxdata, r_rx_sr, r_tx;
  logic            r_rx_valid, r_tx_ovf, r_rx_ovr;
  logic [15:0]     r_div;
  logic            r_cpol, r_cpha, r_lsb;
  logic            r_sclk, r_mosi, r_cs_n;
  logic [DATA_WIDTH-1:0] w_rdata;

  logic [2:0] w_waddr, w_raddr, w_n;
  logic       w_wr0, w_wr1, w_busy, w_tx_wr, w_start, w_abort, w_half_done;
  logic       w_lead, w_st_wr, w_rd_clr;

  assign w_waddr     = bus.i_addr_w[4:2];
  assign w_raddr     = bus.i_addr_r[4:2];
  assign w_wr0       = bus.i_valid_w & r_wen[0];
  assign w_wr1       = bus.i_valid_w & r_wen[1];
  assign w_busy      = (r_state != S_IDLE);
  assign w_tx_wr     = w_wr0 && (w_waddr == c_reg_txdata);
  assign w_start     = w_tx_wr && r_ctrl[0] && !w_busy;
  assign w_st_wr     = w_wr0 && (w_waddr == c_reg_status);
  assign w_rd_clr    = bus.i_valid_r && (w_raddr == c_reg_rxdata);
  assign w_ctrl_nxt  = (w_wr0 && (w_waddr == c_reg_ctrl)) ? bus.i_data_w[5:0] : r_ctrl;
  // EN is judged on the post-write value so an abort lands on the commit edge
  assign w_abort     = w_busy && !w_ctrl_nxt[0];
  assign w_half_done = (r_cnt == r_div);
  assign w_n         = w_hp_nxt[3:1];
  assign w_lead      = ~w_hp_nxt[0];

  function automatic logic bit_of(input logic [7:0] d, input logic lsb, input logic [2:0] n);
    return lsb ? d[n] : d[3'd7 - n];
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 16'd1;
    w_hp_nxt     = r_hp;
    w_edge       = 1'b0;
    w_enter_hold = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 16'd0;
        if (w_start) begin
          w_state_nxt = S_SETUP;
          w_hp_nxt    = 4'd0;
        end
      end
      S_SETUP: if (w_half_done) begin
        w_state_nxt = S_SHIFT;
        w_cnt_nxt   = 16'd0;
        w_hp_nxt    = 4'd0;
        w_edge      = 1'b1;
      end
      S_SHIFT: if (w_half_done) begin
        w_cnt_nxt = 16'd0;
        if (r_hp == 4'd15) begin
          w_state_nxt  = S_HOLD;
          w_enter_hold = 1'b1;
        end else begin
          w_hp_nxt = r_hp + 4'd1;
          w_edge   = 1'b1;
        end
      end
      S_HOLD: if (w_half_done) begin
        w_state_nxt = S_IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = 16'd0;
      w_edge       = 1'b0;
      w_enter_hold = 1'b0;
      w_done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_hp    <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hp    <= w_hp_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wen      <= 4'd0;
      r_ctrl     <= 6'd0;
      r_clkdiv   <= 16'h0004;
      r_rxdata   <= 8'd0;
      r_rx_sr    <= 8'd0;
      r_tx       <= 8'd0;
      r_rx_valid <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_div      <= 16'd0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      if (bus.i_wen != 4'd0)  r_wen <= bus.i_wen;
      else if (bus.i_valid_w) r_wen <= 4'd0;

      r_ctrl <= w_ctrl_nxt;
      if (w_wr0 && (w_waddr == c_reg_clkdiv)) r_clkdiv[7:0]  <= bus.i_data_w[7:0];
      if (w_wr1 && (w_waddr == c_reg_clkdiv)) r_clkdiv[15:8] <= bus.i_data_w[15:8];

      if (w_start) begin
        r_div  <= r_clkdiv;
        r_cpol <= r_ctrl[1];
        r_cpha <= r_ctrl[2];
        r_lsb  <= r_ctrl[3];
        r_tx   <= bus.i_data_w[7:0];
      end

      if (w_start)           r_sclk <= r_ctrl[1];
      else if (w_abort)      r_sclk <= w_ctrl_nxt[1];
      else if (w_edge)       r_sclk <= ~r_sclk;
      else if (w_enter_hold) r_sclk <= r_cpol;
      else if (!w_busy)      r_sclk <= w_ctrl_nxt[1];

      // Leading edges of CPHA=1 and trailing edges of CPHA=0 advance MOSI
      if (w_start) begin
        r_mosi <= bit_of(bus.i_data_w[7:0], r_ctrl[3], 3'd0);
      end else if (w_edge) begin
        if (w_lead && r_cpha)
          r_mosi <= bit_of(r_tx, r_lsb, w_n);
        else if (!w_lead && !r_cpha && (w_n != 3'd7))
          r_mosi <= bit_of(r_tx, r_lsb, w_n + 3'd1);
      end
      if (w_edge && (w_lead ^ r_cpha))
        r_rx_sr[r_lsb ? w_n : (3'd7 - w_n)] <= i_spi_miso;

      if (w_start)      r_cs_n <= 1'b0;
      else if (w_abort) r_cs_n <= 1'b1;
      else if (w_done)  r_cs_n <= ~w_ctrl_nxt[5];
      else if (!w_busy) r_cs_n <= r_cs_n | ~w_ctrl_nxt[5];

      if (w_done) r_rxdata <= r_rx_sr;
      r_rx_valid <= w_done | (r_rx_valid & ~w_rd_clr);
      r_rx_ovr   <= (w_done & r_rx_valid) | (r_rx_ovr & ~(w_st_wr & bus.i_data_w[3]));
      r_tx_ovf   <= (w_tx_wr & ~w_start) | (r_tx_ovf & ~(w_st_wr & bus.i_data_w[2]));
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      c_reg_ctrl:   w_rdata[5:0]  = r_ctrl;
      c_reg_clkdiv: w_rdata[15:0] = r_clkdiv;
      c_reg_rxdata: w_rdata[7:0]  = r_rxdata;
      c_reg_status: w_rdata[3:0]  = {r_rx_ovr, r_tx_ovf, r_rx_valid, w_busy};
      default:      w_rdata       = '0;
    endcase
  end

  assign bus.o_data_r = w_rdata;
  assign o_spi_sclk   = r_sclk;
  assign o_spi_mosi   = r_mosi;
  assign o_spi_cs_n   = r_cs_n;
  assign o_irq        = r_ctrl[4] & r_rx_valid;

  // Only the register-select bits and low 16 data bits carry meaning
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, bus.i_addr_w[ADDR_WIDTH-1:5], bus.i_addr_w[1:0],
                           bus.i_addr_r[ADDR_WIDTH-1:5], bus.i_addr_r[1:0],
                           bus.i_data_w[DATA_WIDTH-1:16]};

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
// Module  : tb_spi_master_ctrl
// Brief   : Directed bench for spi_master_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master_ctrl;

  localparam logic [31:0] c_ctrl   = 32'h00;
  localparam logic [31:0] c_clkdiv = 32'h04;
  localparam logic [31:0] c_txdata = 32'h08;
  localparam logic [31:0] c_rxdata = 32'h0C;
  localparam logic [31:0] c_status = 32'h10;
  localparam logic [31:0] c_unmap  = 32'h14;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sclk, mosi, cs_n, irq;
  logic loop_en = 1'b0;
  logic miso_val = 1'b0;
  logic miso;
  int   n_checks = 0;
  int   n_errors = 0;

  assign miso = loop_en ? mosi : miso_val;

  spi_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  spi_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .o_spi_sclk (sclk),
    .o_spi_mosi (mosi),
    .o_spi_cs_n (cs_n),
    .i_spi_miso (miso),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] wen);
    @(negedge clk);
    bus.i_wen = wen;
    @(negedge clk);
    bus.i_wen = 4'd0;
    bus.i_addr_w = a;
    bus.i_data_w = d;
    bus.i_valid_w = 1'b1;
    @(negedge clk);
    bus.i_valid_w = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    bus.i_addr_r = a;
    #1;
    d = bus.o_data_r;
  endtask

  task automatic rd_clear();
    @(negedge clk);
    bus.i_addr_r = c_rxdata;
    bus.i_valid_r = 1'b1;
    @(negedge clk);
    bus.i_valid_r = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    bus.i_addr_r = c_status;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (bus.o_data_r[0] === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_idle_timeout: busy still %b, required 0", tag, bus.o_data_r[0]);
    end
  endtask

  // Watches one transfer from the negedge right after the TXDATA commit.
  task automatic mon_xfer(input logic cpol, input int budget, output int pulses,
                          output logic [7:0] bits, output int t1, output int t2,
                          output int busy_idx, output logic mosi0, output logic cs0);
    logic prev;
    int   tog;
    prev = cpol; tog = 0; pulses = 0; bits = 8'd0;
    t1 = -1; t2 = -1; busy_idx = -1; mosi0 = 1'b0; cs0 = 1'b1;
    bus.i_addr_r = c_status;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (i == 0) begin
        mosi0 = mosi;
        cs0   = cs_n;
      end
      if (sclk !== prev) begin
        tog++;
        if (tog == 1) t1 = i;
        if (tog == 2) t2 = i;
        if (sclk !== cpol) begin
          pulses++;
          bits = {bits[6:0], mosi};
        end
      end
      prev = sclk;
      if (bus.o_data_r[0] === 1'b0) begin
        busy_idx = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [5];
    logic [31:0] exps  [5];
    addrs = '{c_ctrl, c_clkdiv, c_rxdata, c_status, c_unmap};
    exps  = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      reg_read(addrs[i], d);
      n_checks++;
      if (d !== exps[i]) begin
        n_errors++;
        $display("FAIL reset_reg_%0h: got %h, required %h", addrs[i], d, exps[i]);
      end
    end
    n_checks++;
    if ({cs_n, sclk, mosi, irq} !== 4'b1000) begin
      n_errors++;
      $display("FAIL reset_pins: cs_n/sclk/mosi/irq got %b, required 1000", {cs_n, sclk, mosi, irq});
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    reg_write(c_clkdiv, 32'h0000_7733, 4'b0010);
    reg_read(c_clkdiv, d);
    n_checks++;
    if (d !== 32'h7704) begin
      n_errors++;
      $display("FAIL strobe_lane1: got %h, required 00007704", d);
    end
    reg_write(c_unmap, 32'hFFFF_FFFF, 4'hF);
    reg_read(c_unmap, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL unmapped_read: got %h, required 0", d);
    end
    reg_write(c_clkdiv, 32'h0, 4'hF);
    reg_read(c_clkdiv, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL clkdiv_write: got %h, required 0", d);
    end
  endtask

  task automatic test_mode0();
    logic [31:0] d;
    logic [7:0]  bits;
    int pulses, t1, t2, bidx;
    logic m0, c0;
    loop_en = 1'b1;
    reg_write(c_ctrl, 32'h01, 4'hF);
    reg_write(c_txdata, 32'hA5, 4'hF);
    mon_xfer(1'b0, 60, pulses, bits, t1, t2, bidx, m0, c0);
    n_checks++;
    if (c0 !== 1'b0) begin n_errors++; $display("FAIL mode0_cs_low: got %b, required 0", c0); end
    n_checks++;
    if (m0 !== 1'b1) begin n_errors++; $display("FAIL mode0_setup_mosi: got %b, required 1", m0); end
    n_checks++;
    if (pulses != 8) begin n_errors++; $display("FAIL mode0_pulses: got %0d, required 8", pulses); end
    n_checks++;
    if (bits !== 8'hA5) begin n_errors++; $display("FAIL mode0_mosi_bits: got %h, required a5", bits); end
    n_checks++;
    if (bidx != 18) begin n_errors++; $display("FAIL mode0_busy_clear: got %0d, required 18", bidx); end
    reg_read(c_rxdata, d);
    n_checks++;
    if (d !== 32'hA5) begin n_errors++; $display("FAIL mode0_rxdata: got %h, required a5", d); end
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h2) begin n_errors++; $display("FAIL mode0_status: got %h, required 2", d); end
    rd_clear();
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL mode0_rxvalid_clear: got %h, required 0", d); end
  endtask

  task automatic test_mode3();
    logic [31:0] d;
    logic [7:0]  bits;
    int pulses, t1, t2, bidx;
    logic m0, c0;
    loop_en = 1'b0;
    miso_val = 1'b1;
    reg_write(c_clkdiv, 32'h3, 4'hF);
    reg_write(c_ctrl, 32'h0F, 4'hF);
    #1;
    n_checks++;
    if (sclk !== 1'b1) begin n_errors++; $display("FAIL mode3_idle_sclk: got %b, required 1", sclk); end
    reg_write(c_txdata, 32'h01, 4'hF);
    mon_xfer(1'b1, 120, pulses, bits, t1, t2, bidx, m0, c0);
    n_checks++;
    if ((t2 - t1) != 4) begin n_errors++; $display("FAIL mode3_half_period: got %0d, required 4", t2 - t1); end
    n_checks++;
    if (bits !== 8'h80) begin n_errors++; $display("FAIL mode3_mosi_bits: got %h, required 80", bits); end
    n_checks++;
    if (bidx != 72) begin n_errors++; $display("FAIL mode3_busy_clear: got %0d, required 72", bidx); end
    reg_read(c_rxdata, d);
    n_checks++;
    if (d !== 32'hFF) begin n_errors++; $display("FAIL mode3_rxdata: got %h, required ff", d); end
    n_checks++;
    if (sclk !== 1'b1) begin n_errors++; $display("FAIL mode3_end_sclk: got %b, required 1", sclk); end
    rd_clear();
  endtask

  task automatic test_tx_ovf();
    logic [31:0] d;
    loop_en = 1'b1;
    reg_write(c_clkdiv, 32'h0, 4'hF);
    reg_write(c_ctrl, 32'h00, 4'hF);
    reg_write(c_txdata, 32'h77, 4'hF);
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL ovf_en0: got %h, required 4", d); end
    reg_write(c_status, 32'h04, 4'hF);
    reg_write(c_ctrl, 32'h01, 4'hF);
    reg_write(c_txdata, 32'h3C, 4'hF);
    reg_write(c_txdata, 32'h55, 4'hF);
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h5) begin n_errors++; $display("FAIL ovf_busy: got %h, required 5", d); end
    reg_write(c_status, 32'h04, 4'hF);
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h1) begin n_errors++; $display("FAIL ovf_w1c: got %h, required 1", d); end
    wait_idle("ovf");
    reg_read(c_rxdata, d);
    n_checks++;
    if (d !== 32'h3C) begin n_errors++; $display("FAIL ovf_rxdata: got %h, required 3c", d); end
    rd_clear();
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    reg_write(c_ctrl, 32'h11, 4'hF);
    reg_write(c_txdata, 32'h11, 4'hF);
    wait_idle("ovr1");
    reg_read(c_status, d);
    n_checks++;
    if ({d, irq} !== {32'h2, 1'b1}) begin n_errors++; $display("FAIL ovr_first: status %h irq %b, required 2 1", d, irq); end
    reg_write(c_txdata, 32'h22, 4'hF);
    wait_idle("ovr2");
    reg_read(c_status, d);
    n_checks++;
    if ({d, irq} !== {32'hA, 1'b1}) begin n_errors++; $display("FAIL ovr_second: status %h irq %b, required a 1", d, irq); end
    reg_read(c_rxdata, d);
    n_checks++;
    if (d !== 32'h22) begin n_errors++; $display("FAIL ovr_rxdata: got %h, required 22", d); end
    rd_clear();
    reg_read(c_status, d);
    n_checks++;
    if ({d, irq} !== {32'h8, 1'b0}) begin n_errors++; $display("FAIL ovr_read: status %h irq %b, required 8 0", d, irq); end
    reg_write(c_status, 32'h08, 4'hF);
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL ovr_w1c: got %h, required 0", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic prev;
    int   tog;
    reg_write(c_clkdiv, 32'h3, 4'hF);
    reg_write(c_ctrl, 32'h01, 4'hF);
    reg_write(c_txdata, 32'h99, 4'hF);
    prev = 1'b0;
    tog = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (sclk !== prev) tog++;
      prev = sclk;
      if (tog == 5) break;
      @(negedge clk);
    end
    n_checks++;
    if (tog != 5) begin n_errors++; $display("FAIL abort_edges: got %0d, required 5", tog); end
    reg_write(c_ctrl, 32'h00, 4'hF);
    #1;
    n_checks++;
    if ({cs_n, sclk} !== 2'b10) begin n_errors++; $display("FAIL abort_pins: cs_n/sclk got %b, required 10", {cs_n, sclk}); end
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL abort_status: got %h, required 0", d); end
    repeat (80) @(negedge clk);
    reg_read(c_rxdata, d);
    n_checks++;
    if (d !== 32'h22) begin n_errors++; $display("FAIL abort_rxdata: got %h, required 22", d); end
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL abort_status_late: got %h, required 0", d); end
  endtask

  task automatic test_cs_hold();
    reg_write(c_clkdiv, 32'h0, 4'hF);
    reg_write(c_ctrl, 32'h21, 4'hF);
    #1;
    n_checks++;
    if (cs_n !== 1'b1) begin n_errors++; $display("FAIL cshold_idle: got %b, required 1", cs_n); end
    reg_write(c_txdata, 32'hF0, 4'hF);
    wait_idle("cshold");
    n_checks++;
    if (cs_n !== 1'b0) begin n_errors++; $display("FAIL cshold_kept: got %b, required 0", cs_n); end
    reg_write(c_ctrl, 32'h01, 4'hF);
    #1;
    n_checks++;
    if (cs_n !== 1'b1) begin n_errors++; $display("FAIL cshold_release: got %b, required 1", cs_n); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] addrs [4];
    logic [31:0] exps  [4];
    addrs = '{c_ctrl, c_clkdiv, c_rxdata, c_status};
    exps  = '{32'h0, 32'h4, 32'h0, 32'h0};
    reg_write(c_ctrl, 32'h13, 4'hF);
    reg_write(c_txdata, 32'h81, 4'hF);
    wait_idle("rstmid");
    reg_write(c_txdata, 32'h42, 4'hF);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({cs_n, sclk, mosi, irq} !== 4'b1000) begin
      n_errors++;
      $display("FAIL rstmid_pins: cs_n/sclk/mosi/irq got %b, required 1000", {cs_n, sclk, mosi, irq});
    end
    for (int i = 0; i < 4; i++) begin
      reg_read(addrs[i], d);
      n_checks++;
      if (d !== exps[i]) begin
        n_errors++;
        $display("FAIL rstmid_reg_%0h: got %h, required %h", addrs[i], d, exps[i]);
      end
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    reg_read(c_rxdata, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL rstmid_no_rx: got %h, required 0", d); end
    reg_read(c_status, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL rstmid_status: got %h, required 0", d); end
  endtask

  initial begin
    bus.i_wen     = 4'd0;
    bus.i_addr_w  = 32'd0;
    bus.i_data_w  = 32'd0;
    bus.i_valid_w = 1'b0;
    bus.i_addr_r  = 32'd0;
    bus.i_valid_r = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    resetn = 1'b1;
    test_strobe();
    test_mode0();
    test_mode3();
    test_tx_ovf();
    test_overrun();
    test_abort();
    test_cs_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
